lzrw1_decompressor: RTL and testbench

- Inverse of the LZRW1 compressor. Consumes the compressed item stream: a control bit plus either a literal byte or an offset/length copy.
- Rebuilds the original byte string in an internal sliding history buffer.
- Emits one decompressed byte per cycle over a valid/ready handshake.
- Sits downstream of the compressed-value storage and is used for round-trip checking of the compressor.

---
 rtl/lzrw1_decompressor.sv | 171 +++++++++++++++++
 tb/tb_lzrw1_decompressor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzrw1_decompressor.sv
// LZRW1 decompressor: expands literal/copy items into a byte stream through a
// sliding history buffer, emitting one byte per cycle over valid/ready.
module lzrw1_decompressor #(
    parameter int STRINGSIZE = 4096,
    parameter int HISTSIZE   = 4096,
    parameter int MINMATCH   = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_ctrl,
    input  logic [7:0]  in_byte,
    input  logic [11:0] in_offset,
    input  logic [3:0]  in_length,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic [12:0] byte_count,
    output logic        done,
    output logic        error
);

    localparam int AW = $clog2(HISTSIZE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COPY,
        ST_DRAIN,
        ST_DONE,
        ST_ERROR
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] src_q, src_d;
    logic [4:0]    remaining_q, remaining_d;
    logic          last_q, last_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_byte_q, out_byte_d;
    logic [12:0]   byte_count_q, byte_count_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic [7:0]    hist [HISTSIZE];
    logic [7:0]    hist_rdata;
    logic          adv;
    logic          accept;
    logic          load;
    logic [7:0]    load_byte;
    logic [31:0]   offset_max;
    logic          copy_bad;
    logic          lit_bad;

    always_comb begin
        adv        = !out_valid_q || out_ready;
        in_ready   = !reset && (state_q == ST_IDLE) && adv;
        accept     = in_valid && in_ready;
        // Asynchronous read so an overlapping copy sees bytes written by its own earlier cycles.
        hist_rdata = hist[src_q];

        offset_max = (32'(byte_count_q) < 32'(HISTSIZE - 1)) ? 32'(byte_count_q)
                                                              : 32'(HISTSIZE - 1);
        copy_bad   = (in_offset == 12'd0)
                  || (32'(in_offset) > offset_max)
                  || (32'(byte_count_q) + 32'(in_length) + 32'(MINMATCH) > 32'(STRINGSIZE));
        lit_bad    = 32'(byte_count_q) >= 32'(STRINGSIZE);

        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        src_d        = src_q;
        remaining_d  = remaining_q;
        last_d       = last_q;
        out_valid_d  = out_valid_q;
        out_byte_d   = out_byte_q;
        byte_count_d = byte_count_q;
        done_d       = done_q;
        error_d      = error_q;
        load         = 1'b0;
        load_byte    = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!in_ctrl) begin
                        if (lit_bad) begin
                            state_d = ST_ERROR;
                            error_d = 1'b1;
                        end else begin
                            load      = 1'b1;
                            load_byte = in_byte;
                            if (in_last) state_d = ST_DRAIN;
                        end
                    end else if (copy_bad) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end else begin
                        src_d       = wr_ptr_q - AW'(in_offset);
                        remaining_d = 5'(32'(in_length) + 32'(MINMATCH));
                        last_d      = in_last;
                        state_d     = ST_COPY;
                    end
                end
            end
            ST_COPY: begin
                if (adv) begin
                    load        = 1'b1;
                    load_byte   = hist_rdata;
                    src_d       = src_q + AW'(1);
                    remaining_d = remaining_q - 5'd1;
                    if (remaining_q == 5'd1) state_d = last_q ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (adv) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase

        if (load) begin
            wr_ptr_d     = wr_ptr_q + AW'(1);
            byte_count_d = byte_count_q + 13'd1;
            out_byte_d   = load_byte;
            out_valid_d  = 1'b1;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            src_q        <= '0;
            remaining_q  <= '0;
            last_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_byte_q   <= 8'h00;
            byte_count_q <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            src_q        <= src_d;
            remaining_q  <= remaining_d;
            last_q       <= last_d;
            out_valid_q  <= out_valid_d;
            out_byte_q   <= out_byte_d;
            byte_count_q <= byte_count_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // NOTE: history is deliberately not reset; reads never reach unwritten entries, and a reset would block RAM inference.
    always_ff @(posedge clock) begin
        if (load) hist[wr_ptr_q] <= load_byte;
    end

    assign out_valid  = out_valid_q;
    assign out_byte   = out_byte_q;
    assign byte_count = byte_count_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_lzrw1_decompressor.sv
// Scoreboard bench for lzrw1_decompressor: a byte-list model predicts every
// output byte, and a negedge monitor compares each handshake against it.
module tb_lzrw1_decompressor;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_ctrl;
    logic [7:0]  in_byte;
    logic [11:0] in_offset;
    logic [3:0]  in_length;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic [12:0] byte_count;
    logic        done;
    logic        error;

    int          n_checks = 0;
    int          n_errors = 0;
    int          last_wait;
    logic [7:0]  sb [$];
    logic [7:0]  model [$];
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_byte = 8'h00;

    lzrw1_decompressor dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_byte    (in_byte),
        .in_offset  (in_offset),
        .in_length  (in_length),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .byte_count (byte_count),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within the time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_byte", 32'(out_byte), 32'(stall_byte));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("unexpected_valid", 32'(out_valid), 32'd0);
                else                check("out_byte", 32'(out_byte), 32'(sb.pop_front()));
            end
            stall_prev = out_valid && !out_ready;
            stall_byte = out_byte;
        end
    end

    task automatic send(input logic ctrl, input logic [7:0] b, input logic [11:0] off,
                        input logic [3:0] len, input logic last);
        logic acc;
        int   n;
        in_valid  = 1'b1;
        in_ctrl   = ctrl;
        in_byte   = b;
        in_offset = off;
        in_length = len;
        in_last   = last;
        n   = 0;
        acc = 1'b0;
        do begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 50);
        in_valid  = 1'b0;
        last_wait = n;
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic lit(input logic [7:0] b, input logic last);
        sb.push_back(b);
        model.push_back(b);
        send(1'b0, b, 12'd0, 4'd0, last);
    endtask

    task automatic cpy(input int off, input int len, input logic last, input logic legal);
        logic [7:0] b;
        if (legal) begin
            for (int i = 0; i < len + 3; i++) begin
                b = model[model.size() - off];
                model.push_back(b);
                sb.push_back(b);
            end
        end
        send(1'b1, 8'h00, 12'(off), 4'(len), last);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        #1;
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_byte", 32'(out_byte), 32'd0);
        check("rst_byte_count", 32'(byte_count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        sb.delete();
        model.delete();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        in_valid  = 1'b0;
        in_ctrl   = 1'b0;
        in_byte   = 8'h00;
        in_offset = 12'd0;
        in_length = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        do_reset();

        // Back-to-back literals
        lit(8'h61, 1'b0);
        check("t1_wait0", 32'(last_wait), 32'd1);
        lit(8'h62, 1'b0);
        check("t1_wait1", 32'(last_wait), 32'd1);
        lit(8'h63, 1'b0);
        check("t1_wait2", 32'(last_wait), 32'd1);
        @(negedge clock);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_byte", 32'(out_byte), 32'h63);
        check("t1_count", 32'(byte_count), 32'd3);
        check("t1_in_ready", 32'(in_ready), 32'd1);
        wait_drain("t1_drain");
        do_reset();

        // Run-length copy with offset 1, final item
        lit(8'h41, 1'b0);
        cpy(1, 2, 1'b1, 1'b1);
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (!done) check("t2_in_ready", 32'(in_ready), 32'd0);
        end while (!done && n < 20);
        check("t2_done_latency", 32'(n), 32'd7);
        check("t2_count", 32'(byte_count), 32'd6);
        check("t2_valid_off", 32'(out_valid), 32'd0);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);
        do_reset();

        // Non-overlapping copy, first byte latency
        lit(8'h61, 1'b0);
        lit(8'h62, 1'b0);
        lit(8'h63, 1'b0);
        lit(8'h64, 1'b0);
        cpy(4, 0, 1'b0, 1'b1);
        @(negedge clock);
        check("t3_gap", 32'(out_valid), 32'd0);
        @(negedge clock);
        check("t3_first_valid", 32'(out_valid), 32'd1);
        check("t3_first_byte", 32'(out_byte), 32'h61);
        wait_drain("t3_drain");
        check("t3_count", 32'(byte_count), 32'd7);
        do_reset();

        // Same copy with a three-cycle consumer stall
        lit(8'h61, 1'b0);
        lit(8'h62, 1'b0);
        lit(8'h63, 1'b0);
        lit(8'h64, 1'b0);
        cpy(4, 0, 1'b0, 1'b1);
        repeat (2) @(posedge clock);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("t4_stall_count", 32'(byte_count), 32'd6);
        out_ready = 1'b1;
        wait_drain("t4_drain");
        check("t4_count", 32'(byte_count), 32'd7);
        do_reset();

        // Copy reaching before the stream start
        cpy(2, 0, 1'b0, 1'b0);
        @(negedge clock);
        check("t5_error", 32'(error), 32'd1);
        check("t5_in_ready", 32'(in_ready), 32'd0);
        check("t5_valid", 32'(out_valid), 32'd0);
        repeat (5) @(negedge clock);
        check("t5_in_ready_held", 32'(in_ready), 32'd0);
        check("t5_error_held", 32'(error), 32'd1);
        do_reset();

        // Zero offset
        lit(8'h11, 1'b0);
        cpy(0, 1, 1'b0, 1'b0);
        wait_drain("t5b_drain");
        check("t5b_error", 32'(error), 32'd1);
        check("t5b_count", 32'(byte_count), 32'd1);
        do_reset();

        // Offset beyond produced bytes; pending literal still drains
        lit(8'h11, 1'b0);
        lit(8'h22, 1'b0);
        cpy(3, 0, 1'b0, 1'b0);
        wait_drain("t5c_drain");
        check("t5c_error", 32'(error), 32'd1);
        check("t5c_count", 32'(byte_count), 32'd2);
        check("t5c_in_ready", 32'(in_ready), 32'd0);
        do_reset();

        // Reset in the middle of a long copy
        lit(8'h55, 1'b0);
        cpy(1, 15, 1'b0, 1'b1);
        repeat (5) @(posedge clock);
        #2;
        check("t6_pre_count", 32'(byte_count), 32'd6);
        reset = 1'b1;
        #1;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_byte", 32'(out_byte), 32'd0);
        check("t6_count", 32'(byte_count), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_error", 32'(error), 32'd0);
        sb.delete();
        model.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        lit(8'h7A, 1'b0);
        @(negedge clock);
        check("t6_after_byte", 32'(out_byte), 32'h7A);
        check("t6_after_count", 32'(byte_count), 32'd1);
        wait_drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
